// File: rtl/rx_ts_queue_ctrl.sv
// Circular queue of RX timestamp records with messageType filter, pop handshake,
// saturating overflow counter and a level interrupt, all in the rx_clk domain.
module rx_ts_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          rx_clk,
    input  logic          rx_rst_n,
    input  logic          rx_clk_en_i,
    input  logic          rxts_valid_i,
    input  logic [79:0]   rx_timestamp_i,
    input  logic [15:0]   rx_seqId_i,
    input  logic [3:0]    rx_messageType_i,
    input  logic [79:0]   rx_sourcePortIdentity_i,
    input  logic          q_enable_i,
    input  logic [15:0]   msg_mask_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic          ovf_clr_i,
    output logic          head_valid_o,
    output logic [79:0]   head_timestamp_o,
    output logic [15:0]   head_seqId_o,
    output logic [3:0]    head_messageType_o,
    output logic [79:0]   head_spid_o,
    output logic [AW:0]   level_o,
    output logic [15:0]   overflow_cnt_o,
    output logic          int_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [79:0] mem_ts   [DEPTH];
    logic [15:0] mem_seq  [DEPTH];
    logic [3:0]  mem_type [DEPTH];
    logic [79:0] mem_spid [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic          valid_d;
    logic          push_req;
    logic          accept;
    logic          full;
    logic          pop_ok;
    logic          do_push;
    logic          ovf_evt;

    assign push_req = rxts_valid_i & ~valid_d & rx_clk_en_i;
    assign accept   = push_req & q_enable_i & msg_mask_i[rx_messageType_i];
    assign full     = (level == FULL_LEVEL);
    assign pop_ok   = pop_i & (level != '0);
    // When full, a push only fits if the head leaves in the same cycle.
    assign do_push  = accept & (~full | pop_ok) & ~flush_i;
    assign ovf_evt  = accept & full & ~pop_ok & ~flush_i;

    always_comb begin
        level_next = level;
        if (flush_i) begin
            level_next = '0;
        end else begin
            unique case ({do_push, pop_ok})
                2'b10:   level_next = level + (AW + 1)'(1);
                2'b01:   level_next = level - (AW + 1)'(1);
                default: level_next = level;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            valid_d        <= 1'b0;
            int_o          <= 1'b0;
            overflow_cnt_o <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_ts[i]   <= '0;
                mem_seq[i]  <= '0;
                mem_type[i] <= '0;
                mem_spid[i] <= '0;
            end
        end else begin
            if (rx_clk_en_i) begin
                valid_d <= rxts_valid_i;
            end

            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem_ts[wr_ptr]   <= rx_timestamp_i;
                    mem_seq[wr_ptr]  <= rx_seqId_i;
                    mem_type[wr_ptr] <= rx_messageType_i;
                    mem_spid[wr_ptr] <= rx_sourcePortIdentity_i;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end

            level <= level_next;
            int_o <= (level_next != '0);

            if (ovf_clr_i) begin
                overflow_cnt_o <= ovf_evt ? 16'd1 : 16'd0;
            end else if (ovf_evt && overflow_cnt_o != 16'hFFFF) begin
                overflow_cnt_o <= overflow_cnt_o + 16'd1;
            end
        end
    end

    assign level_o            = level;
    assign head_valid_o       = (level != '0);
    assign head_timestamp_o   = mem_ts[rd_ptr];
    assign head_seqId_o       = mem_seq[rd_ptr];
    assign head_messageType_o = mem_type[rd_ptr];
    assign head_spid_o        = mem_spid[rd_ptr];

endmodule

// File: tb/tb_rx_ts_queue_ctrl.sv
// Directed bench for rx_ts_queue_ctrl: filtering, ordering, full/overflow,
// wrap-around, level-hold edge detect, flush, overflow clear and async reset.
module tb_rx_ts_queue_ctrl;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n;
    logic        rx_clk_en_i;
    logic        rxts_valid_i;
    logic [79:0] rx_timestamp_i;
    logic [15:0] rx_seqId_i;
    logic [3:0]  rx_messageType_i;
    logic [79:0] rx_sourcePortIdentity_i;
    logic        q_enable_i;
    logic [15:0] msg_mask_i;
    logic        pop_i;
    logic        flush_i;
    logic        ovf_clr_i;
    logic        head_valid_o;
    logic [79:0] head_timestamp_o;
    logic [15:0] head_seqId_o;
    logic [3:0]  head_messageType_o;
    logic [79:0] head_spid_o;
    logic [2:0]  level_o;
    logic [15:0] overflow_cnt_o;
    logic        int_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    rx_ts_queue_ctrl #(.DEPTH(4), .AW(2)) dut (
        .rx_clk                  (rx_clk),
        .rx_rst_n                (rx_rst_n),
        .rx_clk_en_i             (rx_clk_en_i),
        .rxts_valid_i            (rxts_valid_i),
        .rx_timestamp_i          (rx_timestamp_i),
        .rx_seqId_i              (rx_seqId_i),
        .rx_messageType_i        (rx_messageType_i),
        .rx_sourcePortIdentity_i (rx_sourcePortIdentity_i),
        .q_enable_i              (q_enable_i),
        .msg_mask_i              (msg_mask_i),
        .pop_i                   (pop_i),
        .flush_i                 (flush_i),
        .ovf_clr_i               (ovf_clr_i),
        .head_valid_o            (head_valid_o),
        .head_timestamp_o        (head_timestamp_o),
        .head_seqId_o            (head_seqId_o),
        .head_messageType_o      (head_messageType_o),
        .head_spid_o             (head_spid_o),
        .level_o                 (level_o),
        .overflow_cnt_o          (overflow_cnt_o),
        .int_o                   (int_o)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic set_rec(input logic [15:0] seq, input logic [3:0] mtype);
        rx_seqId_i              = seq;
        rx_messageType_i        = mtype;
        rx_timestamp_i          = {48'(seq), 32'(seq) + 32'h100};
        rx_sourcePortIdentity_i = {64'hA5A5_0000_0000_0000, seq};
    endtask

    // One rising edge of rxts_valid_i, then a low cycle so the next edge is seen.
    task automatic push(input logic [15:0] seq, input logic [3:0] mtype);
        set_rec(seq, mtype);
        rxts_valid_i = 1'b1;
        tick();
        rxts_valid_i = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] seq);
        check(tag, 80'(head_seqId_o), 80'(seq));
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
    endtask

    initial begin
        rx_rst_n = 1'b0;
        rx_clk_en_i = 1'b1;
        rxts_valid_i = 1'b0;
        set_rec(16'h0, 4'h0);
        q_enable_i = 1'b1;
        msg_mask_i = 16'h0001;
        pop_i = 1'b0;
        flush_i = 1'b0;
        ovf_clr_i = 1'b0;
        tick();
        tick();
        check("rst_level", 80'(level_o), 80'd0);
        check("rst_int", 80'(int_o), 80'd0);
        check("rst_hv", 80'(head_valid_o), 80'd0);
        check("rst_ovf", 80'(overflow_cnt_o), 80'd0);
        check("rst_ts", head_timestamp_o, 80'd0);
        check("rst_seq", 80'(head_seqId_o), 80'd0);
        rx_rst_n = 1'b1;
        tick();

        // 1: single Sync record
        rx_seqId_i = 16'h0010;
        rx_messageType_i = 4'h0;
        rx_timestamp_i = 80'h0000_0000_0001_0000_0100;
        rx_sourcePortIdentity_i = 80'h1122_3344_5566_7788_99AA;
        rxts_valid_i = 1'b1;
        tick();
        check("t1_hv", 80'(head_valid_o), 80'd1);
        check("t1_int", 80'(int_o), 80'd1);
        check("t1_seq", 80'(head_seqId_o), 80'h0010);
        check("t1_ts", head_timestamp_o, 80'h0000_0000_0001_0000_0100);
        check("t1_type", 80'(head_messageType_o), 80'd0);
        check("t1_spid", head_spid_o, 80'h1122_3344_5566_7788_99AA);
        rxts_valid_i = 1'b0;
        tick();
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        check("t1_pop_level", 80'(level_o), 80'd0);
        check("t1_pop_int", 80'(int_o), 80'd0);
        check("t1_pop_hv", 80'(head_valid_o), 80'd0);

        // 2: mask filter
        msg_mask_i = 16'h0002;
        push(16'h0020, 4'h0);
        check("t2_filtered", 80'(level_o), 80'd0);
        push(16'h0021, 4'h1);
        check("t2_level", 80'(level_o), 80'd1);
        check("t2_type", 80'(head_messageType_o), 80'd1);
        check("t2_ovf", 80'(overflow_cnt_o), 80'd0);
        pop_expect("t2_seq", 16'h0021);

        // 3: overflow while full
        msg_mask_i = 16'hFFFF;
        for (int i = 1; i <= 6; i++) push(16'(i), 4'h0);
        check("t3_level", 80'(level_o), 80'd4);
        check("t3_ovf", 80'(overflow_cnt_o), 80'd2);
        for (int i = 1; i <= 4; i++) pop_expect("t3_order", 16'(i));
        check("t3_empty", 80'(level_o), 80'd0);

        // 4: push and pop together while full
        for (int i = 11; i <= 14; i++) push(16'(i), 4'h0);
        set_rec(16'd15, 4'h0);
        rxts_valid_i = 1'b1;
        pop_i = 1'b1;
        tick();
        rxts_valid_i = 1'b0;
        pop_i = 1'b0;
        check("t4_level", 80'(level_o), 80'd4);
        check("t4_ovf", 80'(overflow_cnt_o), 80'd2);
        tick();
        for (int i = 12; i <= 15; i++) pop_expect("t4_order", 16'(i));

        // 5: wrap pointers with interleaved traffic, then a held level
        push(16'd100, 4'h3);
        for (int i = 1; i < 10; i++) begin
            set_rec(16'(100 + i), 4'h3);
            rxts_valid_i = 1'b1;
            check("t5_head", 80'(head_seqId_o), 80'(100 + i - 1));
            pop_i = 1'b1;
            tick();
            rxts_valid_i = 1'b0;
            pop_i = 1'b0;
            check("t5_level", 80'(level_o), 80'd1);
            tick();
        end
        pop_expect("t5_last", 16'd109);
        set_rec(16'd120, 4'h0);
        rxts_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rxts_valid_i = 1'b0;
        tick();
        check("t5_hold_level", 80'(level_o), 80'd1);
        pop_expect("t5_hold_seq", 16'd120);

        // clock enable gates the edge detector
        rx_clk_en_i = 1'b0;
        set_rec(16'd130, 4'h0);
        rxts_valid_i = 1'b1;
        tick();
        check("cen_gated", 80'(level_o), 80'd0);
        rx_clk_en_i = 1'b1;
        tick();
        check("cen_push", 80'(level_o), 80'd1);
        rxts_valid_i = 1'b0;
        tick();
        pop_expect("cen_seq", 16'd130);

        // 6: flush beats a coincident push, then clear beats an overflow
        push(16'd140, 4'h0);
        set_rec(16'd141, 4'h0);
        rxts_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        rxts_valid_i = 1'b0;
        flush_i = 1'b0;
        check("t6_flush_level", 80'(level_o), 80'd0);
        check("t6_flush_int", 80'(int_o), 80'd0);
        check("t6_flush_ovf", 80'(overflow_cnt_o), 80'd2);
        tick();
        for (int i = 200; i < 204; i++) push(16'(i), 4'h0);
        set_rec(16'd204, 4'h0);
        rxts_valid_i = 1'b1;
        ovf_clr_i = 1'b1;
        tick();
        rxts_valid_i = 1'b0;
        ovf_clr_i = 1'b0;
        check("t6_clr_ovf", 80'(overflow_cnt_o), 80'd1);
        check("t6_clr_level", 80'(level_o), 80'd4);
        tick();
        check("t6_head_kept", 80'(head_seqId_o), 80'd200);

        #3;
        rx_rst_n = 1'b0;
        #1;
        check("t6_rst_level", 80'(level_o), 80'd0);
        check("t6_rst_ovf", 80'(overflow_cnt_o), 80'd0);
        check("t6_rst_int", 80'(int_o), 80'd0);
        check("t6_rst_hv", 80'(head_valid_o), 80'd0);
        check("t6_rst_seq", 80'(head_seqId_o), 80'd0);
        check("t6_rst_spid", head_spid_o, 80'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rx_ts_queue_ctrl.md
Name: rx_ts_queue_ctrl

Overview:
Buffers per-message RX timestamp records produced by the RX timestamp engine into a DEPTH-entry circular queue, so that back-to-back PTP messages are not lost before software reads them.
It filters records by PTP messageType, presents the oldest record to the register block through a pop handshake, and counts overflows.
It raises a level interrupt while records are pending.
It sits between the RX timestamp engine outputs and the TSU register file, in the rx_clk domain.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..16)
AW, 2, pointer width = log2(DEPTH)

Ports:
rx_clk  in  1  RX clock (single clock for the block)
rx_rst_n  in  1  asynchronous active-low reset
rx_clk_en_i  in  1  clock enable for GMII/MII adaptation; gates capture only
rxts_valid_i  in  1  record-valid level from the timestamp engine
rx_timestamp_i  in  80  48-bit seconds + 32-bit nanoseconds
rx_seqId_i  in  16  PTP sequenceId
rx_messageType_i  in  4  PTP messageType
rx_sourcePortIdentity_i  in  80  PTP sourcePortIdentity
q_enable_i  in  1  capture enable
msg_mask_i  in  16  bit n=1 enables capture of messageType n
pop_i  in  1  one-cycle pulse: discard the head record
flush_i  in  1  one-cycle pulse: empty the queue
ovf_clr_i  in  1  one-cycle pulse: clear overflow_cnt_o
head_valid_o  out  1  queue non-empty; head_* fields are valid
head_timestamp_o  out  80  head record timestamp
head_seqId_o  out  16  head record sequenceId
head_messageType_o  out  4  head record messageType
head_spid_o  out  80  head record sourcePortIdentity
level_o  out  AW+1  number of stored records (0..DEPTH)
overflow_cnt_o  out  16  dropped-record counter, saturating
int_o  out  1  registered interrupt, high while level_o != 0

Behaviour:
- Reset (async, rx_rst_n=0):
  - Pointers, level_o, overflow_cnt_o, int_o, head_valid_o and the edge-detect register all go to 0.
  - Storage and head_* outputs read as 0.
- Edge detect:
  - valid_d is updated only when rx_clk_en_i=1.
  - A push request is rxts_valid_i & ~valid_d & rx_clk_en_i.
  - A level held high produces exactly one push.
- Filter: the request is accepted only if q_enable_i=1 and msg_mask_i[rx_messageType_i]=1; otherwise it is ignored silently (no overflow count).
- Write: an accepted push writes all four fields to mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap).
- Pop:
  - pop_i with level_o!=0 increments rd_ptr modulo DEPTH.
  - pop_i with level_o=0 is ignored.
  - pop_i is not gated by rx_clk_en_i.
- Head outputs:
  - head_* are driven from mem[rd_ptr]; head_valid_o = (level_o!=0).
  - The next record is visible the cycle after the pop.
- Push latency: a push accepted in cycle N into an empty queue gives head_valid_o=1 and the new fields at N+1, and int_o=1 at N+1.
- Full (level_o=DEPTH):
  - A push without a simultaneous pop is dropped: storage is unchanged and overflow_cnt_o increments, saturating at 0xFFFF.
  - A push and pop in the same cycle while full: both are performed, level stays DEPTH, no overflow.
- Simultaneous push and pop when 0 < level < DEPTH: both are performed and level is unchanged.
- Simultaneous push and pop when empty: the pop is ignored, the push is accepted, level becomes 1.
- flush_i:
  - Sets wr_ptr=rd_ptr=0 and level=0 next cycle.
  - Has priority over push and pop in the same cycle; the push is discarded without counting overflow.
  - Does not affect overflow_cnt_o.
- ovf_clr_i:
  - Clears overflow_cnt_o next cycle.
  - If an overflow occurs in the same cycle, the counter becomes 1.
- int_o:
  - Registered: int_o(next) = (level_next != 0).
  - Falls the cycle after the last record is popped or flushed.
- q_enable_i deassertion only blocks new captures; stored records remain poppable.

Test Plan:
1. Reset, then one Sync (type 0, mask=0x0001, seqId=0x0010, ts=0x0000_0000_0001_0000_0100) -> head_valid_o=1 and int_o=1 one cycle after the push cycle; head fields match; pop -> level 0, int_o=0 next cycle.
2. Mask=0x0002, send type 0 then type 1 -> only the type 1 record is stored; level_o=1; overflow_cnt_o=0.
3. DEPTH=4: push seqIds 1..6 with no pops -> level_o=4, overflow_cnt_o=2; pops return 1,2,3,4 in order.
4. Queue full, push and pop in the same cycle -> level_o stays 4, overflow unchanged; head sequence advances and the new record appears last.
5. 10 pushes/pops interleaved to wrap the pointers twice -> FIFO order preserved; rxts_valid_i held high for 5 cycles yields exactly one record.
6. Flush coincident with a push; ovf_clr_i coincident with an overflow; rx_rst_n asserted mid-stream -> level 0 and record dropped; counter=1; all outputs 0 immediately.
